// File: rtl/uart_tx_sched.sv
// Round-robin arbiter plus 8N1 serializer: shares one UART TX line among
// NUM_REQ byte producers, paced by an oversampling tick (SAMPLE_RATE ticks per bit).
module uart_tx_sched #(
  parameter int NUM_REQ     = 4,
  parameter int SAMPLE_RATE = 16,
  parameter int DATA_W      = 8,
  localparam int IDX_W      = $clog2(NUM_REQ)
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      tick_in,
  input  logic [NUM_REQ-1:0]        req_valid_in,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_in,
  output logic [NUM_REQ-1:0]        req_ready_out,
  output logic                      tx_out,
  output logic                      busy_out,
  output logic [IDX_W-1:0]          grant_out
);

  localparam int CNT_W = $clog2(SAMPLE_RATE);
  localparam int BIT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    tick_cnt_reg, tick_cnt_next;
  logic [BIT_W-1:0]    bit_idx_reg, bit_idx_next;
  logic [DATA_W-1:0]   shift_reg, shift_next;
  logic [IDX_W-1:0]    grant_reg, grant_next;
  logic [IDX_W-1:0]    last_grant_reg, last_grant_next;
  logic                tx_reg, tx_next;

  logic [DATA_W-1:0]   req_data_arr [NUM_REQ];
  logic                sel_found;
  logic [IDX_W-1:0]    sel_idx;
  logic [IDX_W-1:0]    cand;
  logic                accept;
  logic                bit_end;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_split
      assign req_data_arr[gi] = req_data_in[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Rotating search starting just after the last winner, so the requester
  // just served ends up with the lowest priority.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(last_grant_reg) + k) % NUM_REQ);
      if (!sel_found && req_valid_in[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  // Masked during reset so no producer sees a handshake that is then discarded.
  assign accept        = (state_reg == IDLE) && sel_found && !rst_in;
  assign req_ready_out = accept ? (NUM_REQ'(1) << sel_idx) : '0;
  assign bit_end       = tick_in && (tick_cnt_reg == CNT_W'(SAMPLE_RATE - 1));

  always_comb begin
    state_next      = state_reg;
    tick_cnt_next   = tick_cnt_reg;
    bit_idx_next    = bit_idx_reg;
    shift_next      = shift_reg;
    grant_next      = grant_reg;
    last_grant_next = last_grant_reg;
    tx_next         = 1'b1;

    if (state_reg != IDLE && tick_in) begin
      tick_cnt_next = bit_end ? '0 : tick_cnt_reg + CNT_W'(1);
    end

    case (state_reg)
      IDLE: begin
        if (accept) begin
          shift_next      = req_data_arr[sel_idx];
          grant_next      = sel_idx;
          last_grant_next = sel_idx;
          tick_cnt_next   = '0;
          state_next      = START;
        end
      end
      START: begin
        if (bit_end) begin
          state_next   = DATA;
          bit_idx_next = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_next = shift_reg >> 1;
          if (bit_idx_reg == BIT_W'(DATA_W - 1)) begin
            state_next = STOP;
          end else begin
            bit_idx_next = bit_idx_reg + BIT_W'(1);
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    // Line level is derived from the upcoming state so tx_out is a clean register.
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      default: tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_reg      <= IDLE;
      tick_cnt_reg   <= '0;
      bit_idx_reg    <= '0;
      shift_reg      <= '0;
      grant_reg      <= '0;
      last_grant_reg <= IDX_W'(NUM_REQ - 1);
      tx_reg         <= 1'b1;
    end else begin
      state_reg      <= state_next;
      tick_cnt_reg   <= tick_cnt_next;
      bit_idx_reg    <= bit_idx_next;
      shift_reg      <= shift_next;
      grant_reg      <= grant_next;
      last_grant_reg <= last_grant_next;
      tx_reg         <= tx_next;
    end
  end

  assign tx_out    = tx_reg;
  assign busy_out  = (state_reg != IDLE);
  assign grant_out = grant_reg;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched: expected (owner, byte) pairs are queued
// when requests are driven and compared against frames decoded from tx_out.
module tb_uart_tx_sched;

  localparam int NR = 4;
  localparam int SR = 16;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          tick;
  logic [NR-1:0] valid;
  logic [NR*DW-1:0] data;
  logic [NR-1:0] ready;
  logic          tx;
  logic          busy;
  logic [1:0]    grant;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  bit tick_cont  = 1'b0;
  int tick_div   = 0;

  typedef struct packed {
    logic [1:0] idx;
    logic [7:0] byte_val;
  } exp_t;
  exp_t exp_q[$];

  uart_tx_sched #(.NUM_REQ(NR), .SAMPLE_RATE(SR), .DATA_W(DW)) dut (
    .clk_in        (clk),
    .rst_in        (rst),
    .tick_in       (tick),
    .req_valid_in  (valid),
    .req_data_in   (data),
    .req_ready_out (ready),
    .tx_out        (tx),
    .busy_out      (busy),
    .grant_out     (grant)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Tick source: one pulse every 4 clocks, or continuously high.
  initial begin
    tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (tick_cont) begin
        tick = 1'b1;
      end else begin
        tick_div = (tick_div + 1) % 4;
        tick     = (tick_div == 0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic pulse_reset();
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
  endtask

  task automatic wait_ready(output logic [NR-1:0] r, output int at, output bit to);
    to = 1'b1;
    r  = '0;
    at = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (ready != '0) begin
        r  = ready;
        at = cyc;
        to = 1'b0;
        break;
      end
    end
  endtask

  // Decodes one frame; bit windows are delimited by counting SR ticks from the
  // first cycle of each bit, which is the exact timing the line must follow.
  task automatic capture(output logic [7:0] d, output logic [1:0] g, output int start_at,
                         output int len, output int low_cnt, output int errs, output bit to);
    logic lvl;
    int   ticks;
    to = 1'b1; d = '0; g = '0; start_at = 0; len = 0; low_cnt = 0; errs = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (tx === 1'b0) begin
        to = 1'b0;
        break;
      end
    end
    if (to) return;
    start_at = cyc;
    g = grant;
    for (int b = 0; b < DW + 2; b++) begin
      if (b > 0) @(negedge clk);
      lvl = tx;
      if (b == 0 && lvl !== 1'b0) errs++;
      if (b == DW + 1 && lvl !== 1'b1) errs++;
      if (b >= 1 && b <= DW) d[b-1] = lvl;
      ticks = 0;
      for (int c = 0; c < 5000; c++) begin
        if (c > 0) @(negedge clk);
        len++;
        if (tx === 1'b0) low_cnt++;
        if (tx !== lvl || busy !== 1'b1 || ready !== '0 || grant !== g) errs++;
        if (tick) ticks++;
        if (ticks == SR) break;
      end
      if (ticks != SR) errs++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    compared++;
    if (grant !== 2'd0) begin
      mismatched++;
      $display("FAIL reset_grant: actual=%0d required=0", grant);
    end
    for (int i = 0; i < 200; i++) begin
      if (i > 0) @(negedge clk);
      compared++;
      if (tx !== 1'b1 || busy !== 1'b0 || ready !== '0) begin
        mismatched++;
        $display("FAIL reset_idle cyc%0d: actual tx=%b busy=%b ready=%b required tx=1 busy=0 ready=0000",
                 i, tx, busy, ready);
      end
    end
  endtask

  task automatic test_single();
    logic [NR-1:0] r; int r_at; bit to;
    logic [7:0] d; logic [1:0] g; int s_at, len, low, errs;
    exp_t e;
    // Line the accept cycle up with a tick so the frame is exactly 640 clocks.
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #2;
      if (tick) break;
    end
    valid = 4'b0100;
    data[2*DW +: DW] = 8'hA5;
    exp_q.push_back('{idx: 2'd2, byte_val: 8'hA5});
    wait_ready(r, r_at, to);
    compared++;
    if (to || r !== 4'b0100) begin
      mismatched++;
      $display("FAIL single_ready: actual=%b timeout=%0d required=0100", r, to);
    end
    @(posedge clk); #2;
    valid = '0;
    data  = '1;
    capture(d, g, s_at, len, low, errs, to);
    e = exp_q.pop_front();
    compared++;
    if (to || d !== e.byte_val || g !== e.idx) begin
      mismatched++;
      $display("FAIL single_frame: actual data=%h grant=%0d timeout=%0d required data=%h grant=%0d",
               d, g, to, e.byte_val, e.idx);
    end
    compared++;
    if (errs != 0 || len != 640) begin
      mismatched++;
      $display("FAIL single_timing: actual len=%0d errs=%0d required len=640 errs=0", len, errs);
    end
    compared++;
    if (s_at - r_at != 1) begin
      mismatched++;
      $display("FAIL single_latency: actual=%0d required=1", s_at - r_at);
    end
    @(negedge clk);
    compared++;
    if (busy !== 1'b0 || tx !== 1'b1) begin
      mismatched++;
      $display("FAIL single_end: actual busy=%b tx=%b required busy=0 tx=1", busy, tx);
    end
  endtask

  task automatic test_round_robin();
    logic [NR-1:0] r; int r_at; bit to;
    logic [7:0] d; logic [1:0] g; int s_at, len, low, errs;
    int prev_end;
    exp_t e;
    pulse_reset();
    for (int i = 0; i < NR; i++) data[i*DW +: DW] = 8'h10 + 8'(i);
    valid = 4'b1111;
    for (int k = 0; k < 5; k++) exp_q.push_back('{idx: 2'(k % NR), byte_val: 8'h10 + 8'(k % NR)});
    prev_end = 0;
    for (int k = 0; k < 5; k++) begin
      e = exp_q.pop_front();
      wait_ready(r, r_at, to);
      compared++;
      if (to || r !== (4'b0001 << e.idx)) begin
        mismatched++;
        $display("FAIL rr_ready%0d: actual=%b timeout=%0d required=%b", k, r, to, 4'b0001 << e.idx);
      end
      if (k > 0) begin
        compared++;
        if (r_at - prev_end != 1) begin
          mismatched++;
          $display("FAIL rr_gap%0d: actual=%0d required=1", k, r_at - prev_end);
        end
      end
      if (k == 4) begin
        @(posedge clk); #2;
        valid = '0;
      end
      capture(d, g, s_at, len, low, errs, to);
      prev_end = cyc;
      compared++;
      if (to || errs != 0 || d !== e.byte_val || g !== e.idx) begin
        mismatched++;
        $display("FAIL rr_frame%0d: actual data=%h grant=%0d errs=%0d timeout=%0d required data=%h grant=%0d",
                 k, d, g, errs, to, e.byte_val, e.idx);
      end
    end
  endtask

  task automatic test_priority();
    logic [NR-1:0] r; int r_at; bit to;
    logic [7:0] d; logic [1:0] g; int s_at, len, low, errs;
    exp_t e;
    pulse_reset();
    data[3*DW +: DW] = 8'h33;
    data[0*DW +: DW] = 8'h44;
    valid = 4'b1000;
    exp_q.push_back('{idx: 2'd3, byte_val: 8'h33});
    for (int k = 0; k < 3; k++) begin
      e = exp_q.pop_front();
      wait_ready(r, r_at, to);
      compared++;
      if (to || r !== (4'b0001 << e.idx)) begin
        mismatched++;
        $display("FAIL prio_ready%0d: actual=%b timeout=%0d required=%b", k, r, to, 4'b0001 << e.idx);
      end
      if (k != 1) begin
        @(posedge clk); #2;
        valid = '0;
      end
      capture(d, g, s_at, len, low, errs, to);
      compared++;
      if (to || errs != 0 || d !== e.byte_val || g !== e.idx) begin
        mismatched++;
        $display("FAIL prio_frame%0d: actual data=%h grant=%0d errs=%0d timeout=%0d required data=%h grant=%0d",
                 k, d, g, errs, to, e.byte_val, e.idx);
      end
      if (k == 0) begin
        valid = 4'b1001;
        exp_q.push_back('{idx: 2'd0, byte_val: 8'h44});
        exp_q.push_back('{idx: 2'd3, byte_val: 8'h33});
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [NR-1:0] r; int r_at; bit to;
    logic [7:0] d; logic [1:0] g; int s_at, len, low, errs;
    exp_t e;
    pulse_reset();
    valid = 4'b0010;
    data[1*DW +: DW] = 8'h3C;
    wait_ready(r, r_at, to);
    compared++;
    if (to || r !== 4'b0010) begin
      mismatched++;
      $display("FAIL rst_first_ready: actual=%b timeout=%0d required=0010", r, to);
    end
    @(posedge clk); #2;
    valid = '0;
    // Middle of data bit 4: start bit plus four data bits have passed.
    repeat (5 * 64 + 32) @(negedge clk);
    @(posedge clk); #2;
    valid = 4'b0101;
    data[0*DW +: DW] = 8'h5A;
    data[2*DW +: DW] = 8'hC3;
    exp_q.push_back('{idx: 2'd0, byte_val: 8'h5A});
    @(negedge clk);
    compared++;
    if (busy !== 1'b1 || ready !== '0) begin
      mismatched++;
      $display("FAIL rst_inflight: actual busy=%b ready=%b required busy=1 ready=0000", busy, ready);
    end
    @(posedge clk); #2;
    rst = 1'b1;
    @(negedge clk);
    compared++;
    if (ready !== '0) begin
      mismatched++;
      $display("FAIL rst_cycle_ready: actual=%b required=0000", ready);
    end
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    compared++;
    if (tx !== 1'b1 || busy !== 1'b0 || ready !== 4'b0001) begin
      mismatched++;
      $display("FAIL rst_after: actual tx=%b busy=%b ready=%b required tx=1 busy=0 ready=0001", tx, busy, ready);
    end
    @(posedge clk); #2;
    valid = '0;
    capture(d, g, s_at, len, low, errs, to);
    e = exp_q.pop_front();
    compared++;
    if (to || errs != 0 || d !== e.byte_val || g !== e.idx) begin
      mismatched++;
      $display("FAIL rst_frame: actual data=%h grant=%0d errs=%0d timeout=%0d required data=%h grant=%0d",
               d, g, errs, to, e.byte_val, e.idx);
    end
  endtask

  task automatic test_continuous_tick();
    logic [NR-1:0] r; int r_at; bit to;
    logic [7:0] d; logic [1:0] g; int s_at, len, low, errs;
    exp_t e;
    pulse_reset();
    tick_cont = 1'b1;
    valid = 4'b0001;
    data[0*DW +: DW] = 8'h00;
    exp_q.push_back('{idx: 2'd0, byte_val: 8'h00});
    wait_ready(r, r_at, to);
    compared++;
    if (to || r !== 4'b0001) begin
      mismatched++;
      $display("FAIL cont_ready: actual=%b timeout=%0d required=0001", r, to);
    end
    @(posedge clk); #2;
    valid = '0;
    capture(d, g, s_at, len, low, errs, to);
    e = exp_q.pop_front();
    compared++;
    if (to || errs != 0 || d !== e.byte_val || g !== e.idx) begin
      mismatched++;
      $display("FAIL cont_frame: actual data=%h grant=%0d errs=%0d timeout=%0d required data=%h grant=%0d",
               d, g, errs, to, e.byte_val, e.idx);
    end
    compared++;
    if (len != 160 || low != 144) begin
      mismatched++;
      $display("FAIL cont_timing: actual len=%0d low=%0d required len=160 low=144", len, low);
    end
    tick_cont = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    valid = '0;
    data  = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_priority();
    test_reset_mid_frame();
    test_continuous_tick();
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_drain: actual=%0d left required=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
